// File: rtl/program_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : program_counter_unit
// Purpose  : Program counter with branch/jump/link, operator-confirmed INPUT
//            wait and terminal HALT, driven by a 3-state sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module program_counter_unit #(
    parameter int                  PC_WIDTH     = 11,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pc_write_en,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                link,
    input  logic                halt,
    input  logic                io_wait,
    input  logic                confirm_btn,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] link_addr,
    output logic                waiting,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] c_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT_IO = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_nextPc;
    logic [PC_WIDTH-1:0] r_linkAddr;
    logic [PC_WIDTH-1:0] w_nextLinkAddr;
    logic [PC_WIDTH-1:0] w_pcPlusOne;
    logic                r_confirmQ;
    logic                w_confirmRise;

    // Natural truncation to PC_WIDTH bits gives the modulo wrap.
    assign w_pcPlusOne   = r_pc + c_ONE;
    assign w_confirmRise = confirm_btn & ~r_confirmQ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_VECTOR;
            r_linkAddr <= '0;
            r_confirmQ <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_pc       <= w_nextPc;
            r_linkAddr <= w_nextLinkAddr;
            r_confirmQ <= confirm_btn;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextPc       = r_pc;
        w_nextLinkAddr = r_linkAddr;
        case (r_state)
            S_RUN: begin
                if (pc_write_en) begin
                    if (halt) begin
                        w_nextState = S_HALTED;
                    end else if (io_wait) begin
                        w_nextState = S_WAIT_IO;
                    end else if (jump) begin
                        w_nextPc = jump_target;
                        if (link) begin
                            w_nextLinkAddr = w_pcPlusOne;
                        end
                    end else if (branch) begin
                        w_nextPc = branch_target;
                    end else begin
                        w_nextPc = w_pcPlusOne;
                    end
                end
            end
            S_WAIT_IO: begin
                // A button already held on entry never produces a rise.
                if (w_confirmRise) begin
                    w_nextPc    = w_pcPlusOne;
                    w_nextState = S_RUN;
                end
            end
            S_HALTED: begin
                w_nextState = S_HALTED;
            end
            default: begin
                w_nextState = S_RUN;
            end
        endcase
    end

    assign PC        = r_pc;
    assign link_addr = r_linkAddr;
    assign waiting   = (r_state == S_WAIT_IO);
    assign halted    = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_program_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_counter_unit
// Purpose  : Vector table, directed corner sequences and random stimulus
//            checked against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter_unit;

    localparam int W   = 11;
    localparam int MOD = 1 << W;

    logic         clock;
    logic         reset;
    logic         pcWriteEn;
    logic         branch;
    logic [W-1:0] branchTarget;
    logic         jump;
    logic [W-1:0] jumpTarget;
    logic         link;
    logic         halt;
    logic         ioWait;
    logic         confirmBtn;
    logic [W-1:0] pc;
    logic [W-1:0] linkAddr;
    logic         waiting;
    logic         halted;

    int checks   = 0;
    int failures = 0;

    // Reference model state: mode 0 = running, 1 = waiting for operator, 2 = halted
    int mPc;
    int mLink;
    int mMode;
    bit mPrevBtn;

    program_counter_unit #(.PC_WIDTH(W), .RESET_VECTOR('0)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_write_en   (pcWriteEn),
        .branch        (branch),
        .branch_target (branchTarget),
        .jump          (jump),
        .jump_target   (jumpTarget),
        .link          (link),
        .halt          (halt),
        .io_wait       (ioWait),
        .confirm_btn   (confirmBtn),
        .PC            (pc),
        .link_addr     (linkAddr),
        .waiting       (waiting),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit we; bit br; int bt; bit jp; int jt; bit lk; bit hl; bit io; bit cb;
        int ePc; int eLink; bit eWait; bit eHalt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 0; mLink = 0; mMode = 0; mPrevBtn = 0;
    endtask

    task automatic modelStep();
        bit rise;
        rise = confirmBtn && !mPrevBtn;
        if (mMode == 0 && pcWriteEn) begin
            if (halt)        mMode = 2;
            else if (ioWait) mMode = 1;
            else if (jump) begin
                if (link) mLink = (mPc + 1) % MOD;
                mPc = int'(jumpTarget);
            end
            else if (branch) mPc = int'(branchTarget);
            else             mPc = (mPc + 1) % MOD;
        end else if (mMode == 1 && rise) begin
            mPc   = (mPc + 1) % MOD;
            mMode = 0;
        end
        mPrevBtn = confirmBtn;
    endtask

    task automatic compareModel(input string tag);
        chk({tag, ".pc"},      32'(pc),       32'(mPc));
        chk({tag, ".link"},    32'(linkAddr), 32'(mLink));
        chk({tag, ".waiting"}, 32'(waiting),  32'(mMode == 1));
        chk({tag, ".halted"},  32'(halted),   32'(mMode == 2));
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        modelStep();
        @(negedge clock);
        compareModel(tag);
    endtask

    task automatic drive(input bit we, input bit br, input int bt, input bit jp, input int jt,
                         input bit lk, input bit hl, input bit io, input bit cb);
        pcWriteEn = we; branch = br; branchTarget = W'(bt); jump = jp; jumpTarget = W'(jt);
        link = lk; halt = hl; ioWait = io; confirmBtn = cb;
    endtask

    // Assert reset between edges, check its immediate effect, release on a falling edge.
    task automatic asyncReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        chk({tag, ".pc"},      32'(pc),       32'd0);
        chk({tag, ".link"},    32'(linkAddr), 32'd0);
        chk({tag, ".waiting"}, 32'(waiting),  32'd0);
        chk({tag, ".halted"},  32'(halted),   32'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t vecs[20];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        modelReset();
        chk("rst.pc",      32'(pc),       32'd0);
        chk("rst.link",    32'(linkAddr), 32'd0);
        chk("rst.waiting", 32'(waiting),  32'd0);
        chk("rst.halted",  32'(halted),   32'd0);
        @(negedge clock);
        reset = 1'b1;

        //          we br  bt    jp  jt    lk hl io cb   pc    link  wt ht
        vecs[0]  = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   1,    0,    0, 0};
        vecs[1]  = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   2,    0,    0, 0};
        vecs[2]  = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   3,    0,    0, 0};
        vecs[3]  = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   4,    0,    0, 0};
        vecs[4]  = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   5,    0,    0, 0};
        vecs[5]  = '{1, 1, 7,    0, 0,    0, 0, 0, 0,   7,    0,    0, 0};
        vecs[6]  = '{1, 1, 50,   1, 100,  1, 0, 0, 0,   100,  8,    0, 0};
        vecs[7]  = '{0, 0, 0,    1, 5,    1, 0, 0, 0,   100,  8,    0, 0};
        vecs[8]  = '{1, 0, 0,    0, 0,    1, 0, 0, 0,   101,  8,    0, 0};
        vecs[9]  = '{1, 1, 2047, 0, 0,    0, 0, 0, 0,   2047, 8,    0, 0};
        vecs[10] = '{1, 0, 0,    0, 0,    0, 0, 0, 0,   0,    8,    0, 0};
        vecs[11] = '{1, 0, 0,    1, 2047, 1, 0, 0, 0,   2047, 1,    0, 0};
        vecs[12] = '{1, 0, 0,    1, 20,   1, 0, 0, 0,   20,   0,    0, 0};
        vecs[13] = '{1, 0, 0,    1, 9,    1, 0, 1, 0,   20,   0,    1, 0};
        vecs[14] = '{1, 1, 3,    1, 3,    1, 1, 0, 0,   20,   0,    1, 0};
        vecs[15] = '{1, 0, 0,    0, 0,    0, 0, 0, 1,   21,   0,    0, 0};
        vecs[16] = '{1, 0, 0,    0, 0,    0, 0, 0, 1,   22,   0,    0, 0};
        vecs[17] = '{1, 0, 0,    0, 0,    0, 1, 1, 1,   22,   0,    0, 1};
        vecs[18] = '{1, 0, 0,    1, 4,    1, 0, 0, 0,   22,   0,    0, 1};
        vecs[19] = '{1, 1, 9,    0, 0,    0, 0, 1, 1,   22,   0,    0, 1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].we, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].jt,
                  vecs[i].lk, vecs[i].hl, vecs[i].io, vecs[i].cb);
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tpc", i),   32'(pc),       32'(vecs[i].ePc));
            chk($sformatf("vec%0d.tlink", i), 32'(linkAddr), 32'(vecs[i].eLink));
            chk($sformatf("vec%0d.twait", i), 32'(waiting),  32'(vecs[i].eWait));
            chk($sformatf("vec%0d.thalt", i), 32'(halted),   32'(vecs[i].eHalt));
        end

        // Mid-count asynchronous reset, then counting resumes on the first edge.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        asyncReset("rst1");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("count");
        chk("count.pc3", 32'(pc), 32'd3);
        #2;
        asyncReset("rstMid");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("resume");
        chk("resume.pc", 32'(pc), 32'd1);

        // Entry into WAIT_IO with the button already held.
        drive(1, 0, 0, 1, 20, 0, 0, 0, 0);
        cycle("toPc20");
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("ioEnter");
        for (int i = 0; i < 10; i++) begin
            drive(1, i[0], 77, i[1], 88, 1, i[2], 1, 1);
            cycle("ioHeld");
            chk("ioHeld.pc", 32'(pc), 32'd20);
            chk("ioHeld.waiting", 32'(waiting), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("ioRelease");
        chk("ioRelease.pc", 32'(pc), 32'd20);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("ioPress");
        chk("ioPress.pc", 32'(pc), 32'd21);
        chk("ioPress.waiting", 32'(waiting), 32'd0);

        // HALT is terminal until reset.
        drive(1, 1, 30, 0, 0, 0, 0, 0, 0);
        cycle("toPc30");
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle("haltEnter");
        for (int i = 0; i < 20; i++) begin
            drive(1, i[0], 500, i[1], 600, 1, 0, i[2], i[0]);
            cycle("haltHeld");
            chk("haltHeld.pc", 32'(pc), 32'd30);
            chk("haltHeld.halted", 32'(halted), 32'd1);
        end
        #3;
        asyncReset("rstHalt");

        // Randomised run against the reference model.
        begin
            int haltCount;
            haltCount = 0;
            for (int i = 0; i < 4000; i++) begin
                pcWriteEn    = ($urandom_range(0, 9) != 0);
                branch       = ($urandom_range(0, 3) == 0);
                jump         = ($urandom_range(0, 4) == 0);
                link         = $urandom_range(0, 1) == 1;
                halt         = ($urandom_range(0, 199) == 0);
                ioWait       = ($urandom_range(0, 29) == 0);
                branchTarget = W'($urandom);
                jumpTarget   = W'($urandom);
                if ($urandom_range(0, 9) < 3) confirmBtn = ~confirmBtn;
                cycle("rand");
                haltCount = (mMode == 2) ? haltCount + 1 : 0;
                if (haltCount > 20 || $urandom_range(0, 299) == 0) begin
                    #($urandom_range(1, 3));
                    asyncReset("randRst");
                    haltCount = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
